ps2_key_ctrl: RTL and testbench
===============================

// Module: ps2_key_ctrl
// PURPOSE
//  Sequences the byte stream from the PS/2 receiver (key_rdy/key_out) into letter keystrokes for the enigma core.
//  - Decodes scan-code set 2: E0 (extended) and F0 (break) prefixes.
//  - Suppresses typematic repeats of a held key.
//  - Buffers letter indices 0..25 in a small FIFO with a valid/ready handshake toward the rotor datapath.
// PARAMETERS
//  DEPTH        4          FIFO entries; power of 2, >=2
//  TIMEOUT_CYC  1000000    prefix watchdog, clk cycles (20 ms @ 50 MHz); used only with KEYCTRL_TIMEOUT_EN
// PORTS
//  clk          in   1   system clock
//  rst_l        in   1   asynchronous active-low reset
//  key_rdy      in   1   1-cycle strobe from PS/2 receiver: key_out holds a valid byte
//  key_out      in   8   received scan-code byte
//  letter_valid out  1   FIFO non-empty; letter is valid
//  letter       out  5   head-of-FIFO letter index, A=0 .. Z=25
//  letter_ready in   1   consumer accepts letter this cycle
//  fifo_cnt     out  $clog2(DEPTH+1)  entries held
//  ovf          out  1   sticky: a letter was dropped because the FIFO was full
//  ovf_clr      in   1   synchronous clear of ovf
//  timeout      out  1   1-cycle pulse on watchdog abort; tied 0 without the macro
// BEHAVIOUR
//  Reset (async, rst_l=0):
//   - state=IDLE, held code cleared, FIFO emptied, watchdog cleared.
//   - Outputs: letter_valid=0, letter=0, fifo_cnt=0, ovf=0, timeout=0.
//  Byte handling: one byte consumed per key_rdy cycle. Bytes are ignored when key_rdy=0.
//  Decoder FSM, updated on key_rdy:
//   IDLE:    E0->EXT; F0->BRK;
//            letter code->make (stay IDLE); any other code->ignored (stay IDLE)
//   EXT:     F0->EXT_BRK; any other->IDLE (extended make, discarded)
//   BRK:     any->IDLE; if byte==held code, clear held
//   EXT_BRK: any->IDLE (extended break, discarded; held unaffected)
//  Letter codes (set 2):
//   A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A
//   N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A
//  Make rules:
//   - If code==held: drop it (typematic repeat).
//   - Otherwise: held<=code and push the letter index to the FIFO.
//   - Only one key is tracked: pressing B while A is held sets held=B. A subsequent F0 1C is then ignored because it does not match held.
//  FIFO and handshake:
//   - letter_valid=!empty; letter=head entry, registered.
//   - Pop when letter_valid && letter_ready.
//   - Latency: key_rdy with the final byte of a make at cycle N -> letter_valid=1 at N+1 when the FIFO is empty.
//   - Push and pop in the same cycle: both occur and fifo_cnt is unchanged. This also holds when full: the push is accepted.
//   - Push while full with no pop: byte dropped, ovf<=1, FIFO unchanged.
//   - ovf_clr and a new overflow in the same cycle: ovf stays 1.
//   - Read/write pointers wrap modulo DEPTH. fifo_cnt ranges 0..DEPTH.
//   - letter_ready while empty: no effect, no underflow.
// CONFIGURATION
//  KEYCTRL_TIMEOUT_EN defined:
//   - Counter runs while state is EXT, BRK or EXT_BRK and reloads on each key_rdy.
//   - Reaching TIMEOUT_CYC: state<=IDLE, timeout pulses 1 cycle, held unchanged.
//   - key_rdy in the same cycle as expiry wins: the byte is processed and there is no timeout.
//  KEYCTRL_TIMEOUT_EN undefined: no counter; timeout tied 0; a lone prefix waits indefinitely.
// TESTING
//  1. Bytes 1C, F0, 1C with letter_ready=1
//     -> one letter=0 beat 1 cycle after the first key_rdy; held cleared; fifo_cnt returns to 0.
//  2. Bytes 15,15,15,F0,15,15 (Q pressed, repeats, released, pressed again)
//     -> exactly two letter=16 outputs.
//  3. Bytes E0,1C then E0,F0,1C
//     -> no FIFO push, state IDLE; a following 1C yields letter=0.
//  4. DEPTH=4, letter_ready=0, five distinct letter makes 1C,32,21,23,24
//     -> fifo_cnt=4, ovf=1, heads pop 0,1,2,3; ovf_clr clears ovf.
//  5. FIFO full plus a new make key_rdy in the same cycle as a pop
//     -> push accepted, fifo_cnt stays 4, ovf stays 0.
//  6. KEYCTRL_TIMEOUT_EN, TIMEOUT_CYC=100: byte F0 then idle for 100 cycles
//     -> timeout pulse, state IDLE; next 1C yields letter=0.
//     Also: assert rst_l mid-sequence after E0 -> all outputs 0 and state IDLE immediately.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 scan-code sequencer: decodes E0/F0 prefixes, drops typematic repeats and queues letter indices.
// Optional prefix watchdog enabled by defining KEYCTRL_TIMEOUT_EN.
module ps2_key_ctrl #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       key_rdy,
  input  logic [7:0]                 key_out,
  output logic                       letter_valid,
  output logic [4:0]                 letter,
  input  logic                       letter_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic                       timeout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_bad_param
    $error("ps2_key_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_e;

  state_e          state_q, state_d;
  logic [7:0]      held_q, held_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [4:0]      mem_q [DEPTH];
  logic            push, pop, full, wr_en, expire;
  logic [5:0]      dec;

  // {is_letter, index}; 8'h00 never decodes, so it doubles as "nothing held"
  function automatic logic [5:0] decode(input logic [7:0] code);
    case (code)
      8'h1C: decode = {1'b1, 5'd0};   8'h32: decode = {1'b1, 5'd1};
      8'h21: decode = {1'b1, 5'd2};   8'h23: decode = {1'b1, 5'd3};
      8'h24: decode = {1'b1, 5'd4};   8'h2B: decode = {1'b1, 5'd5};
      8'h34: decode = {1'b1, 5'd6};   8'h33: decode = {1'b1, 5'd7};
      8'h43: decode = {1'b1, 5'd8};   8'h3B: decode = {1'b1, 5'd9};
      8'h42: decode = {1'b1, 5'd10};  8'h4B: decode = {1'b1, 5'd11};
      8'h3A: decode = {1'b1, 5'd12};  8'h31: decode = {1'b1, 5'd13};
      8'h44: decode = {1'b1, 5'd14};  8'h4D: decode = {1'b1, 5'd15};
      8'h15: decode = {1'b1, 5'd16};  8'h2D: decode = {1'b1, 5'd17};
      8'h1B: decode = {1'b1, 5'd18};  8'h2C: decode = {1'b1, 5'd19};
      8'h3C: decode = {1'b1, 5'd20};  8'h2A: decode = {1'b1, 5'd21};
      8'h1D: decode = {1'b1, 5'd22};  8'h22: decode = {1'b1, 5'd23};
      8'h35: decode = {1'b1, 5'd24};  8'h1A: decode = {1'b1, 5'd25};
      default: decode = 6'd0;
    endcase
  endfunction

  assign dec = decode(key_out);

`ifdef KEYCTRL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q;

  always_comb begin
    wd_d   = '0;
    expire = 1'b0;
    if (!key_rdy && state_q != S_IDLE) begin
      if (wd_q == WD_W'(TIMEOUT_CYC - 1)) expire = 1'b1;
      else                                wd_d   = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    push    = 1'b0;
    if (key_rdy) begin
      case (state_q)
        S_IDLE: begin
          if (key_out == 8'hE0)      state_d = S_EXT;
          else if (key_out == 8'hF0) state_d = S_BRK;
          else if (dec[5] && key_out != held_q) begin
            held_d = key_out;
            push   = 1'b1;
          end
        end
        S_EXT:   state_d = (key_out == 8'hF0) ? S_EXT_BRK : S_IDLE;
        S_BRK: begin
          state_d = S_IDLE;
          if (key_out == held_q) held_d = 8'h00;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (expire) begin
      state_d = S_IDLE;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle
  assign pop   = (cnt_q != '0) && letter_ready;
  assign full  = (cnt_q == CW'(DEPTH));
  assign wr_en = push && (!full || pop);

  always_comb begin
    rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - CW'(1);
    ovf_d = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    else if (ovf_clr)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= S_IDLE;
      held_q   <= 8'h00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)                                mem_q[gi] <= 5'd0;
      else if (wr_en && wr_ptr_q == PW'(gi))     mem_q[gi] <= dec[4:0];
    end
  end

  assign letter_valid = (cnt_q != '0);
  assign letter       = mem_q[rd_ptr_q];
  assign fifo_cnt     = cnt_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: stimulus pushes expected letters, a negedge monitor pops and compares.
module tb_ps2_key_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_l, key_rdy, letter_ready, ovf_clr;
  logic [7:0] key_out;
  logic       letter_valid, ovf, timeout;
  logic [4:0] letter;
  logic [$clog2(DEPTH+1)-1:0] fifo_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int to_pulses = 0;
  int exp_q[$];

  ps2_key_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_l(rst_l), .key_rdy(key_rdy), .key_out(key_out),
    .letter_valid(letter_valid), .letter(letter), .letter_ready(letter_ready),
    .fifo_cnt(fifo_cnt), .ovf(ovf), .ovf_clr(ovf_clr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_l && timeout) to_pulses++;
    if (rst_l && letter_valid && letter_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_letter", letter, -1);
      end else begin
        int e;
        e = exp_q.pop_front();
        $display("[TB] pop letter=%0d expected=%0d", letter, e);
        check("letter", letter, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    key_rdy = 1'b1;
    key_out = b;
    step();
    key_rdy = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && fifo_cnt != 0; i++) step();
    check(name, int'(fifo_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_l = 1'b0; key_rdy = 1'b0; key_out = 8'h00; letter_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    check("rst_valid", letter_valid, 0);
    check("rst_letter", letter, 0);
    check("rst_cnt", int'(fifo_cnt), 0);
    check("rst_ovf", ovf, 0);
    check("rst_timeout", timeout, 0);
    rst_l = 1'b1;
    step();

    // make, break, make again: held cleared by the break
    letter_ready = 1'b1;
    exp_q.push_back(0);
    send(8'h1C);
    check("t1_latency", letter_valid, 1);
    send(8'hF0); send(8'h1C);
    exp_q.push_back(0);
    send(8'h1C);
    wait_drain("t1_drain");

    // typematic repeats of Q suppressed
    exp_q.push_back(16); exp_q.push_back(16);
    send(8'h15); send(8'h15); send(8'h15); send(8'hF0); send(8'h15); send(8'h15);
    wait_drain("t2_drain");
    check("t2_count", exp_q.size(), 0);

    // extended make/break discarded
    send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
    step(); step();
    check("t3_nopush", int'(fifo_cnt), 0);
    exp_q.push_back(0);
    send(8'h1C);
    wait_drain("t3_drain");
    send(8'hF0); send(8'h1C);

    // fill and overflow
    letter_ready = 1'b0;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    step();
    check("t4_cnt", int'(fifo_cnt), 4);
    check("t4_ovf", ovf, 1);
    check("t4_valid", letter_valid, 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("t4_ovf_clr", ovf, 0);

    // full FIFO: push and pop in the same cycle
    letter_ready = 1'b1;
    exp_q.push_back(25);
    send(8'h1A);
    check("t5_cnt", int'(fifo_cnt), 4);
    check("t5_ovf", ovf, 0);
    wait_drain("t5_drain");

    step(); step(); step();
    check("empty_valid", letter_valid, 0);
    check("empty_cnt", int'(fifo_cnt), 0);

`ifdef KEYCTRL_TIMEOUT_EN
    send(8'hF0);
    for (int i = 0; i < 150 && to_pulses == 0; i++) step();
    check("timeout_seen", to_pulses, 1);
    exp_q.push_back(0);
    send(8'h1C);
    wait_drain("timeout_drain");
`else
    send(8'hF0);
    for (int i = 0; i < 120; i++) step();
    check("timeout_tied", to_pulses, 0);
    send(8'h1C);
    step();
    check("lone_prefix_cnt", int'(fifo_cnt), 0);
`endif

    // asynchronous reset right after an E0 prefix
    send(8'hE0);
    rst_l = 1'b0;
    #1;
    check("rst_mid_valid", letter_valid, 0);
    check("rst_mid_letter", letter, 0);
    check("rst_mid_cnt", int'(fifo_cnt), 0);
    check("rst_mid_ovf", ovf, 0);
    check("rst_mid_timeout", timeout, 0);
    step();
    rst_l = 1'b1;
    step();
    exp_q.push_back(0);
    send(8'h1C);
    check("rst_mid_idle", letter_valid, 1);
    wait_drain("rst_mid_drain");

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
